debug_rom_arbiter: RTL

//   Shares the single-port debug ROM between NumReq requesters (port 0 =

---
 rtl/debug_rom_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/debug_rom_arbiter.sv
// debug_rom_arbiter
//   Shares a single-port debug ROM between NumReq requesters (port 0 =
//   instruction fetch, port 1 = debug-module data/SBA reads). Round-robin
//   arbitration grants one requester per cycle. The winner's address is
//   range- and alignment-checked before it reaches the ROM. The response
//   (rvalid/err/rdata) returns to the granted port exactly one cycle after
//   the grant. Fully pipelined: one access per cycle can be sustained.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   req_i        per-port request (hold with addr until granted)
//   addr_i       per-port byte address, port k at [k*AddrWidth +: AddrWidth]
//   gnt_o        per-port grant, combinational, one-hot or zero
//   rvalid_o     per-port response valid, one cycle after the grant
//   rdata_o      per-port read data, port k at [k*DataWidth +: DataWidth]
//   err_o        per-port error, qualified by rvalid_o
//   rom_req_o    ROM request (granted and address is good)
//   rom_addr_o   ROM byte address (winner's address)
//   rom_rdata_i  ROM data, valid the cycle after rom_req_o
module debug_rom_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned RomSize   = 19
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [NumReq*DataWidth-1:0]   rdata_o,
  output logic [NumReq-1:0]             err_o,
  output logic                          rom_req_o,
  output logic [AddrWidth-1:0]          rom_addr_o,
  input  logic [DataWidth-1:0]          rom_rdata_i
);

  localparam int unsigned IdxW = $clog2(RomSize);
  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [PtrW:0]   NumReqW  = (PtrW+1)'(NumReq);
  localparam logic [PtrW-1:0] LastPort = PtrW'(NumReq - 1);
  localparam logic [IdxW:0]   RomSizeW = (IdxW+1)'(RomSize);

  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [PtrW-1:0]      win;
  logic [PtrW:0]        cand;
  logic                 any_req;
  logic [NumReq-1:0]    gnt;
  logic [NumReq-1:0]    rvalid_q, rvalid_d;
  logic [NumReq-1:0]    err_q, err_d;
  logic [AddrWidth-1:0] win_addr;
  logic [IdxW-1:0]      win_idx;
  logic                 bad;

  // Round-robin pick: first asserted request at or after ptr_q, cyclically.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!any_req && req_i[cand[PtrW-1:0]]) begin
        any_req = 1'b1;
        win     = cand[PtrW-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held so nothing leaks out during reset.
  always_comb begin
    gnt = '0;
    if (any_req && rst_ni) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    win_addr = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (win == PtrW'(i)) begin
        win_addr = addr_i[i*AddrWidth +: AddrWidth];
      end
    end
  end

  // Misaligned, high bits set, or word index past the end of the ROM.
  always_comb begin
    win_idx = win_addr[IdxW+2:3];
    bad     = (|win_addr[2:0])
            | (|win_addr[AddrWidth-1:IdxW+3])
            | ({1'b0, win_idx} >= RomSizeW);
  end

  always_comb begin
    rvalid_d = gnt;
    err_d    = gnt & {NumReq{bad}};
    ptr_d    = ptr_q;
    if (|gnt) begin
      ptr_d = (win == LastPort) ? '0 : win + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // ROM data arrives in the response cycle, so it is steered combinationally
  // by the registered grant; errored responses return zero.
  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (rvalid_q[i] && !err_q[i]) begin
        rdata_o[i*DataWidth +: DataWidth] = rom_rdata_i;
      end
    end
  end

  assign gnt_o      = gnt;
  assign rvalid_o   = rvalid_q;
  assign err_o      = err_q;
  assign rom_req_o  = (|gnt) & ~bad;
  assign rom_addr_o = win_addr;

endmodule
